// File: rtl/mips_pkg.sv
// Definitions shared by the iitk_mini_mips core and its program loader:
// loader state encoding, loader error codes and the text segment base address.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_HALT
    } ldr_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_STRAY   = 2'd3;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/loader_watchdog.sv
// RUN-cycle counter (saturating) plus timeout detect; count is registered, timeout is a
// same-cycle flag for the FSM. No handshake, never stalls.
module loader_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        run_i,
    output logic [31:0] run_cycles_o,
    output logic        timeout_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [32:0] cnt_inc;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 33'd1;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != '1)) begin
            cnt_d = cnt_inc[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign run_cycles_o = cnt_q;
    // Fires on the RUN cycle that brings the count to the limit, so HALT shows exactly TIMEOUT_CYC.
    assign timeout_o = (TIMEOUT_CYC != 0) && run_i && (cnt_inc >= 33'(TIMEOUT_CYC));

endmodule

// File: rtl/imem_program_loader.sv
// Streams instruction words into imem via the core init port, then runs the core until PC passes
// the program end or the watchdog expires. Write latency 1 cycle; s_ready holds off words outside LOAD.
module imem_program_loader import mips_pkg::*; #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] BASE_PC     = TEXT_BASE,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              init_mode,
    output logic              cpu_reset,
    input  logic [31:0]       pc_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] checksum,
    output logic [31:0]       run_cycles
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    ldr_state_t        state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic              s_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              init_mode_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        err_code_q;
    logic [DATA_W-1:0] checksum_q;

    logic              len_ok;
    logic              start_ok;
    logic              accept;
    logic              stray;
    logic              timeout;
    logic [ADDR_W:0]   count_inc;
    logic [31:0]       end_pc;

    assign len_ok    = (length != '0) && (length <= MAX_LEN);
    assign start_ok  = start && !abort && len_ok &&
                       ((state_q == ST_IDLE) || (state_q == ST_HALT));
    assign accept    = s_valid && s_ready_q && (state_q == ST_LOAD);
    assign stray     = s_valid && (state_q != ST_LOAD);
    assign count_inc = count_q + ONE;
    assign end_pc    = BASE_PC + (32'(len_q) << 2);

    loader_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok),
        .run_i        (state_q == ST_RUN),
        .run_cycles_o (run_cycles),
        .timeout_o    (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            init_mode_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            checksum_q  <= '0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            init_mode_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            // A stray word only records itself when nothing earlier is latched; later writes may override.
            if (stray && !error_q) begin
                error_q    <= 1'b1;
                err_code_q <= ERR_STRAY;
            end
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q      <= length;
                            count_q    <= '0;
                            checksum_q <= '0;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            err_code_q <= ERR_NONE;
                            s_ready_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_LOAD;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BAD_LEN;
                        end
                    end
                end
                ST_LOAD: begin
                    mem_we_q <= accept;
                    if (accept) begin
                        mem_addr_q  <= count_q[ADDR_W-1:0];
                        mem_wdata_q <= s_data;
                        checksum_q  <= checksum_q + s_data;
                        count_q     <= count_inc;
                        if (count_inc == len_q) begin
                            s_ready_q <= 1'b0;
                            state_q   <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    mem_we_q    <= 1'b0;
                    init_mode_q <= 1'b0;
                    cpu_reset_q <= 1'b0;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    if (pc_in == end_pc) begin
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        init_mode_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_HALT;
                    end else if (timeout) begin
                        error_q     <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        cpu_reset_q <= 1'b1;
                        init_mode_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_HALT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign init_mode = init_mode_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign checksum  = checksum_q;

endmodule
